// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand/operator/execute sequencer with ALU watchdog; define CALC_CHAIN_EN to chain results into operand A
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       clear,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       load_a,
  output logic       load_op,
  output logic       load_b,
  output logic       alu_start,
  output logic       load_result,
  output logic       chain_a,
  output logic       clear_regs,
  output logic [2:0] state,
  output logic       busy,
  output logic       error
);
  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_WAIT, S_SHOW, S_ERR} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ALU_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_a_q, load_a_d, load_op_q, load_op_d, load_b_q, load_b_d;
  logic alu_start_q, alu_start_d, load_result_q, load_result_d;
  logic chain_a_q, chain_a_d, clear_regs_q, clear_regs_d;
  logic busy_q, busy_d, error_q, error_d;
  // next state and next strobes; clear overrides everything, code 7 falls back to S_A
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_a_d      = 1'b0;
    load_op_d     = 1'b0;
    load_b_d      = 1'b0;
    alu_start_d   = 1'b0;
    load_result_d = 1'b0;
    chain_a_d     = 1'b0;
    clear_regs_d  = 1'b0;
    case (state_q)
      S_A:    if (enter) begin load_a_d = 1'b1; state_d = S_OP; end
      S_OP:   if (enter) begin load_op_d = 1'b1; state_d = S_B; end
      S_B:    if (enter) begin load_b_d = 1'b1; state_d = S_EXEC; end
      S_EXEC: begin alu_start_d = 1'b1; state_d = S_WAIT; cnt_d = '0; end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_done) begin
          load_result_d = !alu_err;
          state_d       = alu_err ? S_ERR : S_SHOW;
        end else if (cnt_q == LAST) state_d = S_ERR;
      end
`ifdef CALC_CHAIN_EN
      S_SHOW: if (enter) begin chain_a_d = 1'b1; state_d = S_OP; end
`else
      S_SHOW: if (enter) begin clear_regs_d = 1'b1; state_d = S_A; end
`endif
      S_ERR:  state_d = S_ERR;
      default: state_d = S_A;
    endcase
    if (clear) begin
      {load_a_d, load_op_d, load_b_d, alu_start_d, load_result_d, chain_a_d} = '0;
      clear_regs_d = 1'b1;
      state_d      = S_A;
      cnt_d        = '0;
    end
    busy_d  = (state_d == S_EXEC) || (state_d == S_WAIT);
    error_d = state_d == S_ERR;
  end
  // registered state, counter and outputs; reset yields idle S_A with no strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_A;
      cnt_q         <= '0;
      load_a_q      <= 1'b0;
      load_op_q     <= 1'b0;
      load_b_q      <= 1'b0;
      alu_start_q   <= 1'b0;
      load_result_q <= 1'b0;
      chain_a_q     <= 1'b0;
      clear_regs_q  <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_a_q      <= load_a_d;
      load_op_q     <= load_op_d;
      load_b_q      <= load_b_d;
      alu_start_q   <= alu_start_d;
      load_result_q <= load_result_d;
      chain_a_q     <= chain_a_d;
      clear_regs_q  <= clear_regs_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end
  assign load_a      = load_a_q;
  assign load_op     = load_op_q;
  assign load_b      = load_b_q;
  assign alu_start   = alu_start_q;
  assign load_result = load_result_q;
  assign chain_a     = chain_a_q;
  assign clear_regs  = clear_regs_q;
  assign state       = state_q;
  assign busy        = busy_q;
  assign error       = error_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random checks of calc_sequencer against a cycle model of the entry flow
module tb_calc_sequencer;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset = 1'b1, enter = 1'b0, clear = 1'b0, alu_done = 1'b0, alu_err = 1'b0;
  logic load_a, load_op, load_b, alu_start, load_result, chain_a, clear_regs, busy, error;
  logic [2:0] state;
  int checks = 0, errors = 0;
  int ms = 0, mw = 0;
  logic [6:0] es = '0;
  always #5 clk = ~clk;
  calc_sequencer #(.ALU_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enter(enter), .clear(clear), .alu_done(alu_done), .alu_err(alu_err),
    .load_a(load_a), .load_op(load_op), .load_b(load_b), .alu_start(alu_start),
    .load_result(load_result), .chain_a(chain_a), .clear_regs(clear_regs),
    .state(state), .busy(busy), .error(error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic r, input logic e, input logic c, input logic d, input logic x);
    es = '0;
    if (r) begin ms = 0; mw = 0; end
    else if (c) begin es[0] = 1'b1; ms = 0; mw = 0; end
    else if (ms == 0 && e) begin es[6] = 1'b1; ms = 1; end
    else if (ms == 1 && e) begin es[5] = 1'b1; ms = 2; end
    else if (ms == 2 && e) begin es[4] = 1'b1; ms = 3; end
    else if (ms == 3) begin es[3] = 1'b1; ms = 4; mw = 0; end
    else if (ms == 4) begin
      mw++;
      if (d && !x) begin es[2] = 1'b1; ms = 5; end
      else if (d || mw == TO) ms = 6;
    end
    else if (ms == 5 && e) begin
`ifdef CALC_CHAIN_EN
      es[1] = 1'b1; ms = 1;
`else
      es[0] = 1'b1; ms = 0;
`endif
    end
  endtask
  task automatic step(input logic r, input logic e, input logic c, input logic d, input logic x);
    @(negedge clk);
    reset = r; enter = e; clear = c; alu_done = d; alu_err = x;
    @(posedge clk);
    model(r, e, c, d, x);
    #1;
    chk("state", 32'(state), 32'(ms));
    chk("strobes", 32'({load_a, load_op, load_b, alu_start, load_result, chain_a, clear_regs}), 32'(es));
    chk("busy", 32'(busy), 32'(ms == 3 || ms == 4));
    chk("error", 32'(error), 32'(ms == 6));
    chk("onehot", 32'($countones({load_a, load_op, load_b, alu_start, load_result, chain_a, clear_regs}) <= 1), 32'd1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic to_wait();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_clear_regs", 32'(clear_regs), 0);
    idle(9);
    step(0, 1, 0, 0, 0);
    chk("t1_load_a", 32'(load_a), 1);
    chk("t1_s_op", 32'(state), 1);
    idle(9);
    step(0, 1, 0, 0, 0);
    chk("t1_load_op", 32'(load_op), 1);
    idle(9);
    step(0, 1, 0, 0, 0);
    chk("t1_load_b", 32'(load_b), 1);
    chk("t1_busy", 32'(busy), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_alu_start", 32'(alu_start), 1);
    chk("t1_s_wait", 32'(state), 4);
    step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0);
    chk("t2_load_result", 32'(load_result), 1);
    chk("t2_s_show", 32'(state), 5);
    chk("t2_busy", 32'(busy), 0);
    step(0, 0, 0, 0, 0);
    chk("t2_strobe_width", 32'(load_result), 0);
    step(0, 1, 0, 0, 0);
`ifdef CALC_CHAIN_EN
    chk("t6_chain_a", 32'(chain_a), 1);
    chk("t6_state", 32'(state), 1);
    step(0, 0, 1, 0, 0);
`else
    chk("t6_clear_regs", 32'(clear_regs), 1);
    chk("t6_state", 32'(state), 0);
`endif
    to_wait();
    step(0, 0, 0, 1, 1);
    chk("t3_s_err", 32'(state), 6);
    chk("t3_error", 32'(error), 1);
    step(0, 1, 0, 0, 0);
    chk("t3_enter_ignored", 32'(state), 6);
    step(0, 0, 1, 0, 0);
    chk("t3_clear_regs", 32'(clear_regs), 1);
    chk("t3_error_clr", 32'(error), 0);
    step(0, 0, 0, 0, 0);
    chk("t3_clear_width", 32'(clear_regs), 0);
    to_wait();
    idle(TO - 1);
    chk("t4_still_wait", 32'(state), 4);
    step(0, 0, 0, 0, 0);
    chk("t4_timeout", 32'(state), 6);
    step(0, 0, 0, 1, 0);
    chk("t4_done_ignored", 32'(load_result), 0);
    step(0, 0, 1, 0, 0);
    to_wait();
    idle(TO - 1);
    step(0, 0, 0, 1, 0);
    chk("t4_done_wins", 32'(state), 5);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("t5_clear_prio", 32'(clear_regs), 1);
    chk("t5_no_load_op", 32'(load_op), 0);
    chk("t5_state", 32'(state), 0);
    to_wait();
    idle(2);
    step(0, 0, 1, 1, 0);
    chk("t5_abort", 32'(state), 0);
    chk("t5_no_result", 32'(load_result), 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("reset_mid", 32'(state), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(19) == 0,
           $urandom_range(7) == 0, $urandom_range(1) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
